// File: rtl/ifu_inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO, 1-cycle push-to-head latency, in_ready_o drops only when full.
// Optional IFU_QUEUE_BYPASS_EN lets an entry arriving at an empty queue appear on the head outputs in the same cycle.
module ifu_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [INST_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic                     is_pred_branch_i,
  input  logic                     is_pred_jalr_i,
  input  logic [ADDR_W-1:0]        branch_addr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic                     is_pred_branch_o,
  output logic                     is_pred_jalr_o,
  output logic [ADDR_W-1:0]        branch_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INST_W-1:0] INST_NOP = INST_W'(32'h0000_0013);

  logic [INST_W-1:0] r_inst [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [ADDR_W-1:0] r_tgt  [DEPTH];
  logic              r_br   [DEPTH];
  logic              r_jalr [DEPTH];

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef IFU_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && in_valid_i && !flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle is never written.
  assign w_pop  = !w_empty && out_ready_i && !flush_i;
  assign w_push = in_valid_i && !w_full && !flush_i && !(w_bypass && out_ready_i);

  assign in_ready_o  = !w_full;
  assign out_valid_o = !w_empty || w_bypass;
  assign count_o     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_br[i]   <= 1'b0;
        r_jalr[i] <= 1'b0;
      end
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_br[r_wptr]   <= is_pred_branch_i;
        r_jalr[r_wptr] <= is_pred_jalr_i;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_inst[r_wptr] <= inst_i;
      r_addr[r_wptr] <= inst_addr_i;
      r_tgt[r_wptr]  <= branch_addr_i;
    end
  end

  always_comb begin
    inst_o           = INST_NOP;
    inst_addr_o      = '0;
    is_pred_branch_o = 1'b0;
    is_pred_jalr_o   = 1'b0;
    branch_addr_o    = '0;
    if (!w_empty) begin
      inst_o           = r_inst[r_rptr];
      inst_addr_o      = r_addr[r_rptr];
      is_pred_branch_o = r_br[r_rptr];
      is_pred_jalr_o   = r_jalr[r_rptr];
      branch_addr_o    = r_tgt[r_rptr];
    end else if (w_bypass) begin
      inst_o           = inst_i;
      inst_addr_o      = inst_addr_i;
      is_pred_branch_o = is_pred_branch_i;
      is_pred_jalr_o   = is_pred_jalr_i;
      branch_addr_o    = branch_addr_i;
    end
  end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Bench for ifu_inst_queue: queue-based reference model checked every cycle plus directed literal expectations.
module tb_ifu_inst_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        br;
    logic        jalr;
    logic [31:0] tgt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        is_pred_branch_i = 1'b0;
  logic        is_pred_jalr_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        is_pred_branch_o;
  logic        is_pred_jalr_o;
  logic [31:0] branch_addr_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit seen_200 = 1'b0;
  ent_t q[$];

  always #5 clk = ~clk;

  ifu_inst_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .is_pred_branch_i(is_pred_branch_i), .is_pred_jalr_i(is_pred_jalr_i),
    .branch_addr_i(branch_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .is_pred_branch_o(is_pred_branch_o), .is_pred_jalr_o(is_pred_jalr_o),
    .branch_addr_o(branch_addr_o), .count_o(count_o)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs from the queue contents, then the queue update for this edge.
  always @(negedge clk) begin
    if (chk_en) begin
      ent_t cur;
      ent_t head;
      bit   byp;
      bit   exp_vld;
      bit   do_pop;
      bit   do_push;
      cur = '{inst: inst_i, addr: inst_addr_i, br: is_pred_branch_i,
              jalr: is_pred_jalr_i, tgt: branch_addr_i};
`ifdef IFU_QUEUE_BYPASS_EN
      byp = (q.size() == 0) && in_valid_i && !flush_i;
`else
      byp = 1'b0;
`endif
      exp_vld = (q.size() != 0) || byp;
      if (q.size() != 0) head = q[0];
      else if (byp) head = cur;
      else head = '{inst: 32'h13, addr: 32'h0, br: 1'b0, jalr: 1'b0, tgt: 32'h0};

      cmp("m_count", 64'(count_o), 64'(q.size()));
      cmp("m_in_ready", 64'(in_ready_o), 64'(q.size() != DEPTH));
      cmp("m_out_valid", 64'(out_valid_o), 64'(exp_vld));
      cmp("m_inst", 64'(inst_o), 64'(head.inst));
      cmp("m_addr", 64'(inst_addr_o), 64'(head.addr));
      cmp("m_br", 64'(is_pred_branch_o), 64'(head.br));
      cmp("m_jalr", 64'(is_pred_jalr_o), 64'(head.jalr));
      cmp("m_tgt", 64'(branch_addr_o), 64'(head.tgt));
      if (out_valid_o && inst_addr_o == 32'h200) seen_200 = 1'b1;

      if (rst || flush_i) begin
        q.delete();
      end else begin
        do_pop  = (q.size() != 0) && out_ready_i;
        do_push = in_valid_i && (q.size() < DEPTH) && !(byp && out_ready_i);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(cur);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input bit ordy);
    in_valid_i       = v;
    inst_addr_i      = a;
    inst_i           = a ^ 32'hA5A5_0000;
    is_pred_branch_i = a[2];
    is_pred_jalr_i   = a[3];
    branch_addr_i    = a + 32'h40;
    out_ready_i      = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset then idle
    drive(0, 0, 0);
    tick();
    cmp("rst_in_ready", 64'(in_ready_o), 64'd1);
    cmp("rst_out_valid", 64'(out_valid_o), 64'd0);
    cmp("rst_inst_nop", 64'(inst_o), 64'h13);
    cmp("rst_count", 64'(count_o), 64'd0);

    // Fill to DEPTH, 5th push ignored, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0);
      tick();
    end
    cmp("full_count", 64'(count_o), 64'd4);
    cmp("full_in_ready", 64'(in_ready_o), 64'd0);
    drive(1, 32'h110, 0);
    tick();
    cmp("full_5th_ignored", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      #1;
      cmp("drain_addr", 64'(inst_addr_o), 64'(32'h100 + 32'(4 * i)));
      tick();
    end
    cmp("drain_empty", 64'(count_o), 64'd0);

    // Streaming: push 6 while popping from the second cycle, pointers wrap
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h700 + 32'(4 * i), i != 0);
      #1;
      if (i != 0) cmp("stream_head", 64'(inst_addr_o), 64'(32'h700 + 32'(4 * (i - 1))));
      tick();
      cmp("stream_count", 64'(count_o), 64'd1);
    end
    drive(0, 0, 1);
    #1;
    cmp("stream_last", 64'(inst_addr_o), 64'h714);
    cmp("stream_last_tgt", 64'(branch_addr_o), 64'h754);
    cmp("stream_last_br", 64'(is_pred_branch_o), 64'd1);
    tick();
    cmp("stream_drained", 64'(count_o), 64'd0);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h180 + 32'(4 * i), 0);
      tick();
    end
    drive(1, 32'h200, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(0, 0, 1);
    cmp("flush_count", 64'(count_o), 64'd0);
    cmp("flush_valid", 64'(out_valid_o), 64'd0);
    tick();
    tick();
    cmp("flush_no_0x200", 64'(seen_200), 64'd0);

    // Push into empty queue with decode ready
    drive(1, 32'h300, 1);
    #1;
`ifdef IFU_QUEUE_BYPASS_EN
    cmp("byp_same_valid", 64'(out_valid_o), 64'd1);
    cmp("byp_same_addr", 64'(inst_addr_o), 64'h300);
    tick();
    drive(0, 0, 1);
    cmp("byp_count", 64'(count_o), 64'd0);
`else
    cmp("nobyp_same_valid", 64'(out_valid_o), 64'd0);
    tick();
    drive(0, 0, 1);
    cmp("nobyp_next_valid", 64'(out_valid_o), 64'd1);
    cmp("nobyp_next_addr", 64'(inst_addr_o), 64'h300);
    tick();
`endif
    cmp("after_300_empty", 64'(count_o), 64'd0);

    // Reset while full and mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 0);
      tick();
    end
    drive(1, 32'h410, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0);
    cmp("rst2_count", 64'(count_o), 64'd0);
    cmp("rst2_in_ready", 64'(in_ready_o), 64'd1);
    drive(1, 32'h500, 0);
    tick();
    drive(1, 32'h504, 0);
    cmp("rst2_resume_addr", 64'(inst_addr_o), 64'h500);
    cmp("rst2_resume_count", 64'(count_o), 64'd1);
    tick();
    drive(0, 0, 1);
    tick();
    cmp("rst2_second_addr", 64'(inst_addr_o), 64'h504);
    tick();
    drive(0, 0, 0);
    tick();
    cmp("end_empty", 64'(count_o), 64'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
